// File: rtl/lse_simd_pkg.sv
// Shared SIMD lane definitions for the log-space adder and subtractor datapaths.
package lse_simd_pkg;

  localparam int unsigned NUM_CHUNKS = 4;

  typedef enum logic [1:0] {
    MODE_1X24 = 2'b00,
    MODE_2X12 = 2'b01,
    MODE_4X6  = 2'b10,
    MODE_RSVD = 2'b11
  } simd_mode_e;

  // Number of independent lanes for a given mode; reserved behaves as one full lane.
  function automatic logic [2:0] lane_count(simd_mode_e mode);
    case (mode)
      MODE_2X12: lane_count = 3'd2;
      MODE_4X6:  lane_count = 3'd4;
      default:   lane_count = 3'd1;
    endcase
  endfunction

  // Chunks that begin a lane; carries are cut (forced) at these boundaries.
  function automatic logic [3:0] lane_start_mask(simd_mode_e mode);
    case (mode)
      MODE_2X12: lane_start_mask = 4'b0101;
      MODE_4X6:  lane_start_mask = 4'b1111;
      default:   lane_start_mask = 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/lse_div_simd_if.sv
// Valid/ready bus of the SIMD log-space subtractor: request and result channels.
interface lse_div_simd_if #(
  parameter int unsigned WIDTH = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_mode;
  logic             in_sat_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_underflow;
  logic [1:0]       out_mode;
  logic             out_mode_err;

  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_sat_en, out_ready,
    output in_ready, out_valid, out_result, out_underflow, out_mode, out_mode_err
  );

  modport master (
    output in_valid, in_a, in_b, in_mode, in_sat_en, out_ready,
    input  in_ready, out_valid, out_result, out_underflow, out_mode, out_mode_err
  );
endinterface

// File: rtl/lse_sub_chunk.sv
// One chunk of the SIMD subtractor: a + ~b + cin with carry-out (carry-out = no borrow).
module lse_sub_chunk #(
  parameter int unsigned CW = 6
) (
  input  logic          cin,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  output logic [CW-1:0] diff,
  output logic          cout
);
  logic [CW:0] sum;

  assign sum  = {1'b0, a} + {1'b0, ~b} + {{CW{1'b0}}, cin};
  assign diff = sum[CW-1:0];
  assign cout = sum[CW];
endmodule

// File: rtl/lse_div_simd.sv
// Two-stage SIMD log-space subtractor (linear-domain divide) with per-lane underflow and saturation.
module lse_div_simd
  import lse_simd_pkg::*;
#(
  parameter int unsigned WIDTH = 24
) (
  input  logic           clk,
  input  logic           rst,
  lse_div_simd_if.slave  bus
);
  localparam int unsigned CW = WIDTH / NUM_CHUNKS;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  simd_mode_e       s1_mode;
  logic             s1_sat;

  logic             s1_adv;
  logic             s2_adv;

  simd_mode_e       eff_mode;
  logic [3:0]       start;
  logic [CW-1:0]    d0, d1, d2, d3;
  logic             cy0, cy1, cy2, cy3;
  logic [3:0]       lane_uf;
  logic [3:0]       chunk_zero;
  logic [WIDTH-1:0] diff_res;

  // Output stage frees when empty or drained; input stage frees when it can hand off.
  assign s2_adv      = !bus.out_valid || bus.out_ready;
  assign s1_adv      = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  // Reserved mode computes as a single full-width lane.
  assign eff_mode = (s1_mode == MODE_RSVD) ? MODE_1X24 : s1_mode;
  assign start    = lane_start_mask(eff_mode);

  lse_sub_chunk #(.CW(CW)) u_chunk0 (
    .cin (1'b1),
    .a   (s1_a[CW-1:0]),
    .b   (s1_b[CW-1:0]),
    .diff(d0),
    .cout(cy0)
  );

  lse_sub_chunk #(.CW(CW)) u_chunk1 (
    .cin (start[1] | cy0),
    .a   (s1_a[2*CW-1:CW]),
    .b   (s1_b[2*CW-1:CW]),
    .diff(d1),
    .cout(cy1)
  );

  lse_sub_chunk #(.CW(CW)) u_chunk2 (
    .cin (start[2] | cy1),
    .a   (s1_a[3*CW-1:2*CW]),
    .b   (s1_b[3*CW-1:2*CW]),
    .diff(d2),
    .cout(cy2)
  );

  lse_sub_chunk #(.CW(CW)) u_chunk3 (
    .cin (start[3] | cy2),
    .a   (s1_a[4*CW-1:3*CW]),
    .b   (s1_b[4*CW-1:3*CW]),
    .diff(d3),
    .cout(cy3)
  );

  // Lane borrow is the missing carry out of each lane's top chunk; zero masks follow lane spans.
  always_comb begin
    lane_uf    = 4'b0000;
    chunk_zero = 4'b0000;
    case (eff_mode)
      MODE_2X12: begin
        lane_uf    = {2'b00, ~cy3, ~cy1};
        chunk_zero = {{2{~cy3}}, {2{~cy1}}};
      end
      MODE_4X6: begin
        lane_uf    = ~{cy3, cy2, cy1, cy0};
        chunk_zero = ~{cy3, cy2, cy1, cy0};
      end
      default: begin
        lane_uf    = {3'b000, ~cy3};
        chunk_zero = {4{~cy3}};
      end
    endcase
    if (!s1_sat) begin
      chunk_zero = 4'b0000;
    end
  end

  assign diff_res = {chunk_zero[3] ? {CW{1'b0}} : d3,
                     chunk_zero[2] ? {CW{1'b0}} : d2,
                     chunk_zero[1] ? {CW{1'b0}} : d1,
                     chunk_zero[0] ? {CW{1'b0}} : d0};

  // S1 captures operands; S2 registers the finished result and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid          <= 1'b0;
      s1_a              <= '0;
      s1_b              <= '0;
      s1_mode           <= MODE_1X24;
      s1_sat            <= 1'b0;
      bus.out_valid     <= 1'b0;
      bus.out_result    <= '0;
      bus.out_underflow <= 4'b0000;
      bus.out_mode      <= 2'b00;
      bus.out_mode_err  <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_a    <= bus.in_a;
          s1_b    <= bus.in_b;
          s1_mode <= simd_mode_e'(bus.in_mode);
          s1_sat  <= bus.in_sat_en;
        end
      end
      if (s2_adv) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.out_result    <= diff_res;
          bus.out_underflow <= lane_uf;
          bus.out_mode      <= s1_mode;
          bus.out_mode_err  <= (s1_mode == MODE_RSVD);
        end
      end
    end
  end

endmodule

// File: tb/tb_lse_div_simd.sv
// Directed + random bench for lse_div_simd with a result scoreboard and output hold checks.
module tb_lse_div_simd;
  import lse_simd_pkg::*;

  localparam int unsigned WIDTH = 24;

  typedef struct {
    logic [23:0] res;
    logic [3:0]  uf;
    logic [1:0]  mode;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   delivered = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lse_div_simd_if #(.WIDTH(WIDTH)) bus ();

  lse_div_simd #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic [23:0] res, input logic [3:0] uf,
                              input logic [1:0] mode, input logic err);
    exp_t e;
    e.res = res; e.uf = uf; e.mode = mode; e.err = err;
    return e;
  endfunction

  // Reference: per-lane unsigned subtract, independent of the chunk/carry structure.
  function automatic exp_t model(input logic [23:0] a, input logic [23:0] b,
                                 input logic [1:0] mode, input logic sat);
    exp_t e;
    int unsigned lw, n, m, a32, b32, al, bl, d;
    e.res = '0; e.uf = '0; e.mode = mode; e.err = (mode == 2'b11);
    lw  = (mode == 2'b01) ? 12 : (mode == 2'b10) ? 6 : 24;
    n   = 24 / lw;
    m   = (32'd1 << lw) - 32'd1;
    a32 = 32'(a);
    b32 = 32'(b);
    for (int l = 0; l < int'(n); l++) begin
      al = (a32 >> (l * lw)) & m;
      bl = (b32 >> (l * lw)) & m;
      if (al < bl) begin
        e.uf[l] = 1'b1;
        d = sat ? 32'd0 : ((al - bl) & m);
      end else begin
        d = al - bl;
      end
      e.res = e.res | 24'(d << (l * lw));
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one transaction and returns just after its accept edge, leaving in_valid high.
  task automatic send(input logic [23:0] a, input logic [23:0] b,
                      input logic [1:0] mode, input logic sat, input exp_t e);
    bit done;
    done = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_mode   = mode;
    bus.in_sat_en = sat;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      step();
    end
    if (!done) chk("send_timeout", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) step();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: scoreboard pops on transfer, hold checks while stalled.
  initial begin
    exp_t        e;
    logic        p_stall;
    logic [23:0] p_res;
    logic [3:0]  p_uf;
    logic [1:0]  p_mode;
    logic        p_err;
    p_stall = 1'b0;
    p_res = '0; p_uf = '0; p_mode = '0; p_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_stall = 1'b0;
      end else begin
        if (p_stall) begin
          chk("hold_valid", 32'(bus.out_valid), 32'd1);
          chk("hold_result", 32'(bus.out_result), 32'(p_res));
          chk("hold_uf", 32'(bus.out_underflow), 32'(p_uf));
          chk("hold_mode", 32'(bus.out_mode), 32'(p_mode));
          chk("hold_err", 32'(bus.out_mode_err), 32'(p_err));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", 32'(bus.out_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("result", 32'(bus.out_result), 32'(e.res));
            chk("underflow", 32'(bus.out_underflow), 32'(e.uf));
            chk("mode", 32'(bus.out_mode), 32'(e.mode));
            chk("mode_err", 32'(bus.out_mode_err), 32'(e.err));
            delivered++;
          end
        end
        p_stall = bus.out_valid && !bus.out_ready;
        p_res   = bus.out_result;
        p_uf    = bus.out_underflow;
        p_mode  = bus.out_mode;
        p_err   = bus.out_mode_err;
      end
    end
  end

  initial begin
    int d0;
    logic [23:0] ra, rb;
    logic [1:0]  rm;
    logic        rs;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_mode   = 2'b00;
    bus.in_sat_en = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_result", 32'(bus.out_result), 32'd0);
    chk("rst_out_uf", 32'(bus.out_underflow), 32'd0);
    chk("rst_out_mode", 32'(bus.out_mode), 32'd0);
    chk("rst_out_err", 32'(bus.out_mode_err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // Single transfer: latency check (one cycle after accept edge still empty, then valid).
    send(24'h000100, 24'h000001, 2'b00, 1'b0, mk(24'h0000FF, 4'b0000, 2'b00, 1'b0));
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(bus.out_valid), 32'd1);
    step();

    // Directed lane cases, back to back.
    send(24'h800001, 24'h001002, 2'b01, 1'b1, mk(24'h7FF000, 4'b0001, 2'b01, 1'b0));
    send(24'h800001, 24'h001002, 2'b01, 1'b0, mk(24'h7FFFFF, 4'b0001, 2'b01, 1'b0));
    send(24'h040FCA, 24'h08004A, 2'b10, 1'b1, mk(24'h000F80, 4'b1000, 2'b10, 1'b0));
    send(24'h000010, 24'h000020, 2'b11, 1'b0, mk(24'hFFFFF0, 4'b0001, 2'b11, 1'b1));
    send(24'h000020, 24'h000010, 2'b00, 1'b0, mk(24'h000010, 4'b0000, 2'b00, 1'b0));
    send(24'h123456, 24'h123456, 2'b00, 1'b1, mk(24'h000000, 4'b0000, 2'b00, 1'b0));
    send(24'h000000, 24'hFFFFFF, 2'b00, 1'b0, mk(24'h000001, 4'b0001, 2'b00, 1'b0));
    bus.in_valid = 1'b0;
    drain();

    // Random traffic across all modes against the lane model.
    for (int i = 0; i < 24; i++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      rm = 2'($urandom_range(0, 3));
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rm, rs, model(ra, rb, rm, rs));
    end
    bus.in_valid = 1'b0;
    drain();

    // Burst of 8 with a 3-cycle downstream stall mid-burst.
    d0 = delivered;
    for (int i = 0; i < 8; i++) begin
      ra = 24'(32'h00A000 + i * 32'h010203);
      rb = 24'(32'h001000 * i);
      if (i == 4) begin
        bus.out_ready = 1'b0;
        fork
          begin
            @(negedge clk);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b1;
          end
        join_none
      end
      send(ra, rb, 2'(i % 3), 1'(i % 2), model(ra, rb, 2'(i % 3), 1'(i % 2)));
    end
    bus.in_valid = 1'b0;
    drain();
    chk("burst_count", 32'(delivered - d0), 32'd8);

    // Reset with two transactions in flight: both must vanish.
    bus.out_ready = 1'b0;
    send(24'h000005, 24'h000001, 2'b00, 1'b0, mk(24'h000004, 4'b0000, 2'b00, 1'b0));
    send(24'h000007, 24'h000001, 2'b00, 1'b0, mk(24'h000006, 4'b0000, 2'b00, 1'b0));
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("inflight_out_valid", 32'(bus.out_valid), 32'd1);
    step();
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (4) step();
    chk("post_rst_quiet", 32'(bus.out_valid), 32'd0);

    send(24'h000300, 24'h000100, 2'b10, 1'b0, mk(24'h000200, 4'b0000, 2'b10, 1'b0));
    bus.in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
